// File: rtl/pd_pkg.sv
// Shared constants for the serial pattern detector: state encoding and default sizes.
package pd_pkg;

  localparam int unsigned MAXLEN_DEF = 8;
  localparam int unsigned CNTW_DEF   = 8;
  localparam int unsigned LENW       = 4;
  localparam int unsigned STW        = 2;

  typedef logic [STW-1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t FILL = 2'd1;
  localparam state_t RUN  = 2'd2;
  localparam state_t DONE = 2'd3;

endpackage

// File: rtl/pd_matcher.sv
// History shift register plus masked comparison of the post-shift window against the pattern.
module pd_matcher
  import pd_pkg::*;
#(
  parameter int unsigned MAXLEN = MAXLEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              clr,
  input  logic              in_bit,
  input  logic [LENW-1:0]   len,
  input  logic [MAXLEN-1:0] pattern,
  output logic              hit_c
);

  // Only MAXLEN-1 old bits are ever needed; the incoming bit completes the window.
  logic [MAXLEN-2:0] hist;
  logic [MAXLEN-1:0] hist_nxt;
  logic [MAXLEN-1:0] mask;

  // Window as it will look once in_bit is shifted in, and the low-len-bits mask.
  always_comb begin
    hist_nxt = {hist, in_bit};
    mask     = '0;
    for (int unsigned i = 0; i < MAXLEN; i++) begin
      mask[i] = (32'(len) > i);
    end
    hit_c = (((hist_nxt ^ pattern) & mask) == '0);
  end

  // History register; clear takes priority over a shift.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist <= '0;
    end else if (shift_en) begin
      hist <= hist_nxt[MAXLEN-2:0];
    end
  end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Configurable serial pattern detector with run control, match counting and optional limit.
module pattern_detect_ctrl
  import pd_pkg::*;
#(
  parameter int unsigned MAXLEN = MAXLEN_DEF,
  parameter int unsigned CNTW   = CNTW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LENW-1:0]   cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNTW-1:0]   cfg_limit,
  output logic              cfg_err,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              match,
  output logic [CNTW-1:0]   match_count,
  output logic              busy,
  output logic              done
);

  state_t            state;
  state_t            state_nxt;
  logic [MAXLEN-1:0] pat_r;
  logic [LENW-1:0]   len_r;
  logic              ovl_r;
  logic [CNTW-1:0]   lim_r;
  logic [LENW-1:0]   fill_cnt;
  logic [LENW-1:0]   fill_nxt;
  logic [CNTW-1:0]   cnt_nxt;
  logic              match_nxt;
  logic              hist_clr;
  logic              shift_en;
  logic              hit_c;
  logic              cfg_we;
  logic              cfg_ok;
  logic              cfg_bad;
  logic              len_legal;
  logic [LENW-1:0]   len_eff;

  pd_matcher #(.MAXLEN(MAXLEN)) u_matcher (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .clr      (hist_clr),
    .in_bit   (in_bit),
    .len      (len_r),
    .pattern  (pat_r),
    .hit_c    (hit_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, counter and datapath control decode.
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    cnt_nxt   = match_count;
    match_nxt = 1'b0;
    hist_clr  = 1'b0;
    shift_en  = 1'b0;

    cfg_we    = cfg_valid && (state == IDLE);
    len_legal = (cfg_len != '0) && (32'(cfg_len) <= MAXLEN);
    cfg_ok    = cfg_we && len_legal;
    cfg_bad   = cfg_we && !len_legal;
    // A start that coincides with a config write runs with the new length.
    len_eff   = cfg_ok ? cfg_len : len_r;

    case (state)
      IDLE, DONE: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (start) begin
          hist_clr  = 1'b1;
          fill_nxt  = '0;
          cnt_nxt   = '0;
          state_nxt = (len_eff == LENW'(1)) ? RUN : FILL;
        end
      end
      FILL: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (in_valid) begin
          shift_en = 1'b1;
          fill_nxt = fill_cnt + LENW'(1);
          if ((fill_cnt + LENW'(1)) == (len_r - LENW'(1))) begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (in_valid) begin
          shift_en = 1'b1;
          if (hit_c) begin
            match_nxt = 1'b1;
            cnt_nxt   = (match_count == {CNTW{1'b1}}) ? match_count
                                                      : match_count + CNTW'(1);
            if ((lim_r != '0) && (cnt_nxt == lim_r)) begin
              state_nxt = DONE;
            end else if (!ovl_r && (len_r != LENW'(1))) begin
              fill_nxt  = '0;
              state_nxt = FILL;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Config registers, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r       <= '0;
      len_r       <= LENW'(1);
      ovl_r       <= 1'b1;
      lim_r       <= '0;
      fill_cnt    <= '0;
      match_count <= '0;
      match       <= 1'b0;
      cfg_err     <= 1'b0;
      cfg_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (cfg_ok) begin
        pat_r <= cfg_pattern;
        len_r <= cfg_len;
        ovl_r <= cfg_overlap;
        lim_r <= cfg_limit;
      end
      fill_cnt    <= fill_nxt;
      match_count <= cnt_nxt;
      match       <= match_nxt;
      cfg_err     <= cfg_bad;
      cfg_ready   <= (state_nxt == IDLE);
      busy        <= (state_nxt == FILL) || (state_nxt == RUN);
      done        <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Directed bench for pattern_detect_ctrl with a bit-queue reference model.
module tb_pattern_detect_ctrl;

  localparam int unsigned MAXLEN = 8;
  localparam int unsigned CNTW   = 8;
  localparam int unsigned CMAX   = (1 << CNTW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [MAXLEN-1:0] cfg_pattern = '0;
  logic [3:0]        cfg_len = 4'd0;
  logic              cfg_overlap = 1'b0;
  logic [CNTW-1:0]   cfg_limit = '0;
  logic              cfg_err;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_bit = 1'b0;
  logic              match;
  logic [CNTW-1:0]   match_count;
  logic              busy;
  logic              done;

  pattern_detect_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_limit   (cfg_limit),
    .cfg_err     (cfg_err),
    .start       (start),
    .stop        (stop),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .match       (match),
    .match_count (match_count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;
  int errs        = 0;

  // Model: mode 0 = idle, 1 = running, 2 = finished.
  int          m_mode = 0;
  logic [7:0]  m_pat  = '0;
  int          m_len  = 1;
  bit          m_ovl  = 1'b1;
  int          m_lim  = 0;
  int          m_cnt  = 0;
  int          seg    = 0;
  bit          q[$];
  bit          model_ok = 1'b0;
  bit          exp_match, exp_err, exp_ready, exp_busy, exp_done;

  task automatic cmp(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_step();
    bit hit;
    if (rst) begin
      m_mode = 0; m_pat = '0; m_len = 1; m_ovl = 1'b1; m_lim = 0;
      m_cnt = 0; seg = 0; q.delete();
      exp_match = 1'b0; exp_err = 1'b0;
      model_ok = 1'b1;
    end else begin
      exp_match = 1'b0;
      exp_err   = 1'b0;
      if (m_mode == 0 && cfg_valid) begin
        if (cfg_len >= 1 && int'(cfg_len) <= int'(MAXLEN)) begin
          m_pat = cfg_pattern; m_len = int'(cfg_len);
          m_ovl = cfg_overlap; m_lim = int'(cfg_limit);
        end else begin
          exp_err = 1'b1;
        end
      end
      if (m_mode == 1) begin
        if (stop) begin
          m_mode = 0;
        end else if (in_valid) begin
          q.push_back(in_bit);
          if (q.size() > 16) void'(q.pop_front());
          seg++;
          hit = (seg >= m_len);
          for (int i = 0; i < m_len; i++)
            if (hit && q[q.size() - 1 - i] != m_pat[i]) hit = 1'b0;
          if (hit) begin
            exp_match = 1'b1;
            if (m_cnt < int'(CMAX)) m_cnt++;
            if (m_lim != 0 && m_cnt == m_lim) m_mode = 2;
            else if (!m_ovl) seg = 0;
          end
        end
      end else if (stop) begin
        m_mode = 0;
      end else if (start) begin
        q.delete(); seg = 0; m_cnt = 0; m_mode = 1;
      end
    end
    exp_ready = (m_mode == 0);
    exp_busy  = (m_mode == 1);
    exp_done  = (m_mode == 2);
  endtask

  // Model advances on each rising edge; DUT outputs are checked on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (model_ok) begin
        cmp("match", int'(match), int'(exp_match));
        cmp("match_count", int'(match_count), m_cnt);
        cmp("cfg_err", int'(cfg_err), int'(exp_err));
        cmp("cfg_ready", int'(cfg_ready), int'(exp_ready));
        cmp("busy", int'(busy), int'(exp_busy));
        cmp("done", int'(done), int'(exp_done));
        if (match) pulses++;
        if (cfg_err) errs++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic [7:0] lim);
    cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_limit = lim;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  // Sends n bits, first bit taken from bits[n-1].
  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_bit   = bits[n - 1 - i];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic settle();
    idle(2);
    #1;
  endtask

  int p0, e0;

  initial begin
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    #1;
    cmp("rst_count", int'(match_count), 0);
    cmp("rst_ready", int'(cfg_ready), 1);
    cmp("rst_busy", int'(busy), 0);

    // Overlapping 1011 on 1,0,1,1,0,1,1.
    do_cfg(8'b1011, 4'd4, 1'b1, 8'd0);
    do_start();
    p0 = pulses;
    send_bits(16'b1011011, 7);
    settle();
    cmp("ovl_pulses", pulses - p0, 2);
    cmp("ovl_count", int'(match_count), 2);
    do_stop();
    settle();
    cmp("stop_keep_count", int'(match_count), 2);

    // Same stream, non-overlapping.
    do_cfg(8'b1011, 4'd4, 1'b0, 8'd0);
    do_start();
    p0 = pulses;
    send_bits(16'b1011011, 7);
    settle();
    cmp("novl_pulses", pulses - p0, 1);
    cmp("novl_count", int'(match_count), 1);
    do_stop();
    settle();

    // Illegal lengths are rejected; the prior config stays in force.
    e0 = errs;
    do_cfg(8'hFF, 4'd0, 1'b1, 8'd1);
    idle(1);
    do_cfg(8'hFF, 4'd9, 1'b1, 8'd1);
    settle();
    cmp("err_pulses", errs - e0, 2);
    do_start();
    p0 = pulses;
    send_bits(16'b1011011, 7);
    settle();
    cmp("prior_cfg_pulses", pulses - p0, 1);
    do_stop();
    settle();

    // Limit 3 with single-bit pattern.
    do_cfg(8'b1, 4'd1, 1'b1, 8'd3);
    do_start();
    p0 = pulses;
    send_bits(16'b1111, 4);
    settle();
    cmp("lim_pulses", pulses - p0, 3);
    cmp("lim_done", int'(done), 1);
    cmp("lim_count", int'(match_count), 3);

    // Restart from DONE, then start+stop together.
    do_start();
    send_bits(16'b1, 1);
    settle();
    cmp("restart_count", int'(match_count), 1);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    #1;
    cmp("startstop_busy", int'(busy), 0);
    cmp("startstop_count", int'(match_count), 1);
    settle();

    // Reset mid-run with history 101, then a fresh run must refill.
    do_cfg(8'b101, 4'd3, 1'b1, 8'd0);
    do_start();
    send_bits(16'b101, 3);
    settle();
    cmp("pre_rst_count", int'(match_count), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    cmp("mid_rst_count", int'(match_count), 0);
    cmp("mid_rst_busy", int'(busy), 0);
    cmp("mid_rst_match", int'(match), 0);
    do_cfg(8'b101, 4'd3, 1'b1, 8'd0);
    do_start();
    p0 = pulses;
    send_bits(16'b01, 2);
    settle();
    cmp("fresh_fill", pulses - p0, 0);
    send_bits(16'b101, 3);
    settle();
    cmp("fresh_match", pulses - p0, 1);
    do_stop();
    settle();

    // Counter saturation with pulses continuing.
    do_cfg(8'b1, 4'd1, 1'b1, 8'd0);
    do_start();
    p0 = pulses;
    for (int i = 0; i < 260; i++) send_bits(16'b1, 1);
    settle();
    cmp("sat_count", int'(match_count), 255);
    cmp("sat_pulses", pulses - p0, 260);
    do_stop();
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
